// File: rtl/fuvrf_writer_pkg.sv
// Shared definitions for the FUVRF loader and the filter-reduce unit.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package fuvrf_writer_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_WRITE = 2'd2
  } fsm_state_e;

  // Every frame starts with exactly one address byte ahead of the line data.
  localparam int unsigned ADDR_BYTES = 1;

  // Number of data bytes that make up one FUVRF line.
  function automatic int unsigned frame_data_bytes(input int unsigned m,
                                                   input int unsigned dw);
    return (m * dw) / 8;
  endfunction

  // Address width for a FUVRF of n lines; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fuvrf_writer_if.sv
// Config byte stream in, FUVRF RAM write port and status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the byte stream cannot be stalled by the writer.
// Ports: tracing/configId/configData flow from the config source to the
// writer; mem_address/mem_write_enable/mem_in feed the RAM write port
// (address_b/wren_b/data_b); busy/done/error report frame status.
interface fuvrf_writer_if
  import fuvrf_writer_pkg::*;
#(
  parameter int M          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FUVRF_SIZE = 4
) ();

  localparam int ADDR_W = addr_width(FUVRF_SIZE);

  logic                    tracing;
  logic [7:0]              configId;
  logic [7:0]              configData;
  logic [ADDR_W-1:0]       mem_address;
  logic                    mem_write_enable;
  logic [M*DATA_WIDTH-1:0] mem_in;
  logic                    busy;
  logic                    done;
  logic                    error;

  // Config source / observer side.
  modport master (
    output tracing, configId, configData,
    input  mem_address, mem_write_enable, mem_in, busy, done, error
  );

  // Writer side.
  modport slave (
    input  tracing, configId, configData,
    output mem_address, mem_write_enable, mem_in, busy, done, error
  );

endinterface

// File: rtl/fuvrf_writer.sv
// Assembles an address byte plus one line of data bytes into a FUVRF write.
// Latency: write strobe one cycle after the last data byte is accepted.
// Backpressure: none; unselected cycles simply stall the frame, bytes
// offered in the write cycle or while tracing are dropped.
// Ports: clk, reset (async, active-high), bus (fuvrf_writer_if.slave).
module fuvrf_writer
  import fuvrf_writer_pkg::*;
#(
  parameter int M                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int FUVRF_SIZE         = 4,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic          clk,
  input  logic          reset,
  fuvrf_writer_if.slave bus
);

  localparam int BYTES  = frame_data_bytes(M, DATA_WIDTH);
  localparam int CNT_W  = $clog2(BYTES + 1);
  localparam int ADDR_W = addr_width(FUVRF_SIZE);
  localparam int LINE_W = M * DATA_WIDTH;

  fsm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        frame_addr_q, frame_addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_in_q, mem_in_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;

  logic sel;
  logic addr_ok;

  assign sel     = (bus.configId == 8'(PERSONAL_CONFIG_ID));
  // The full address byte is range-checked, so an address that would alias
  // onto a legal line after truncation is still rejected.
  assign addr_ok = (int'(frame_addr_q) < FUVRF_SIZE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_addr_d  = frame_addr_q;
    line_d        = line_q;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;
    wen_d         = 1'b0;
    done_d        = 1'b0;
    error_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel && !bus.tracing) begin
          frame_addr_d = bus.configData;
          cnt_d        = '0;
          state_d      = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bus.tracing) begin
          // Reader took over mid-frame: drop the partial line.
          state_d = ST_IDLE;
          cnt_d   = '0;
          error_d = 1'b1;
        end else if (sel) begin
          for (int b = 0; b < BYTES; b++) begin
            if (cnt_q == CNT_W'(b)) begin
              line_d[b*8 +: 8] = bus.configData;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            state_d = ST_WRITE;
            // The RAM-facing address/data only move on a real commit, so
            // they stay stable across rejected and aborted frames.
            if (addr_ok) begin
              mem_address_d = frame_addr_q[ADDR_W-1:0];
              mem_in_d      = line_d;
              wen_d         = 1'b1;
              done_d        = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
        end
      end

      ST_WRITE: begin
        // Any byte offered in this cycle is dropped.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_addr_q  <= '0;
      line_q        <= '0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      wen_q         <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_addr_q  <= frame_addr_d;
      line_q        <= line_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
      wen_q         <= wen_d;
      done_q        <= done_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.mem_address      = mem_address_q;
  assign bus.mem_write_enable = wen_q;
  assign bus.mem_in           = mem_in_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;

endmodule

// File: tb/tb_fuvrf_writer.sv
// Self-checking bench for fuvrf_writer: directed frames plus random traffic
// compared against a frame-level model built from a byte queue.
module tb_fuvrf_writer;
  import fuvrf_writer_pkg::*;

  localparam int M     = 2;
  localparam int DW    = 32;
  localparam int SIZE  = 4;
  localparam int PID   = 3;
  localparam int BYTES = M * DW / 8;
  localparam int AW    = $clog2(SIZE);
  localparam int LW    = M * DW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fuvrf_writer_if #(.M(M), .DATA_WIDTH(DW), .FUVRF_SIZE(SIZE)) bus ();

  fuvrf_writer #(
    .M(M), .DATA_WIDTH(DW), .FUVRF_SIZE(SIZE), .PERSONAL_CONFIG_ID(PID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: accepted bytes of the current frame, plus a flag for
  // the single write cycle in which input is ignored.
  logic [7:0]    m_q[$];
  bit            m_wr;
  logic          e_wen, e_done, e_err, e_busy;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_data;

  // Monitor tallies for directed tests.
  int            cyc, n_wen, n_done, n_err, n_busy, w_cyc, d_cyc, er_cyc;
  logic [AW-1:0] w_addr;
  logic [LW-1:0] w_data;
  logic          er_busy;

  task automatic model_clear();
    m_q.delete();
    m_wr   = 1'b0;
    e_wen  = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    e_addr = '0;   e_data = '0;
  endtask

  task automatic model_edge(input logic [7:0] id, input logic [7:0] dat, input logic trc);
    bit sel;
    logic [LW-1:0] tmp;
    sel    = (id == 8'(PID)) && !trc;
    e_wen  = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (m_wr) begin
      m_wr   = 1'b0;
      e_busy = 1'b0;
    end else if (m_q.size() > 0) begin
      if (trc) begin
        m_q.delete();
        e_err  = 1'b1;
        e_busy = 1'b0;
      end else if (sel) begin
        m_q.push_back(dat);
        if (m_q.size() == ADDR_BYTES + BYTES) begin
          if (int'(m_q[0]) < SIZE) begin
            e_addr = m_q[0][AW-1:0];
            e_data = '0;
            for (int i = 0; i < BYTES; i++) begin
              tmp      = '0;
              tmp[7:0] = m_q[i + ADDR_BYTES];
              e_data   = e_data | (tmp << (8 * i));
            end
            e_wen  = 1'b1;
            e_done = 1'b1;
          end else begin
            e_err = 1'b1;
          end
          m_q.delete();
          m_wr   = 1'b1;
          e_busy = 1'b1;
        end
      end
    end else if (sel) begin
      m_q.push_back(dat);
      e_busy = 1'b1;
    end
  endtask

  task automatic clr_mon();
    cyc = 0; n_wen = 0; n_done = 0; n_err = 0; n_busy = 0;
    w_cyc = -1; d_cyc = -1; er_cyc = -1; er_busy = 1'b0;
    w_addr = '0; w_data = '0;
  endtask

  // Present one byte for one clock, then sample #1 after the edge.
  task automatic send(input logic [7:0] id, input logic [7:0] dat, input logic trc);
    bus.configId   = id;
    bus.configData = dat;
    bus.tracing    = trc;
    @(posedge clk);
    model_edge(id, dat, trc);
    #1;
    cyc++;
    if (bus.mem_write_enable === 1'b1) begin
      n_wen++; w_cyc = cyc; w_addr = bus.mem_address; w_data = bus.mem_in;
    end
    if (bus.done === 1'b1) begin n_done++; d_cyc = cyc; end
    if (bus.error === 1'b1) begin n_err++; er_cyc = cyc; er_busy = bus.busy; end
    if (bus.busy === 1'b1) n_busy++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [LW-1:0] pack(input logic [7:0] d [BYTES]);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) r = r + (LW'(d[i]) << (8 * i));
    return r;
  endfunction

  task automatic test_reset();
    bus.tracing = 1'b0; bus.configId = 8'd0; bus.configData = 8'd0;
    #1 reset = 1'b1;
    model_clear();
    #2;
    checks += 6;
    if (bus.busy !== 1'b0)             begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", bus.mem_write_enable); end
    if (bus.done !== 1'b0)             begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.error !== 1'b0)            begin errors++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    if (bus.mem_address !== '0)        begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.mem_address); end
    if (bus.mem_in !== '0)             begin errors++; $display("FAIL reset_mem_in got=%h exp=0", bus.mem_in); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_trace_idle();
    clr_mon();
    for (int i = 0; i < 10; i++) send(8'(PID), 8'($urandom_range(0, 3)), 1'b1);
    send(8'd0, 8'd0, 1'b0);
    checks += 3;
    if (n_busy != 0) begin errors++; $display("FAIL trace_idle_busy got=%0d exp=0", n_busy); end
    if (n_wen  != 0) begin errors++; $display("FAIL trace_idle_wen got=%0d exp=0", n_wen); end
    if (n_err  != 0) begin errors++; $display("FAIL trace_idle_err got=%0d exp=0", n_err); end
  endtask

  task automatic test_normal();
    logic [7:0] fr [9];
    fr = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clr_mon();
    for (int i = 0; i < 9; i++) send(8'(PID), fr[i], 1'b0);
    send(8'd0, 8'd0, 1'b0);
    checks += 7;
    if (n_wen != 1)  begin errors++; $display("FAIL normal_wen_count got=%0d exp=1", n_wen); end
    if (w_cyc != 9)  begin errors++; $display("FAIL normal_wen_cycle got=%0d exp=9", w_cyc); end
    if (d_cyc != 9)  begin errors++; $display("FAIL normal_done_cycle got=%0d exp=9", d_cyc); end
    if (w_addr !== 2'd2) begin errors++; $display("FAIL normal_addr got=%0d exp=2", w_addr); end
    if (w_data !== 64'h8877665544332211) begin errors++; $display("FAIL normal_data got=%h exp=8877665544332211", w_data); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL normal_busy_after got=%b exp=0", bus.busy); end
    if (bus.mem_in !== 64'h8877665544332211) begin errors++; $display("FAIL normal_hold got=%h exp=8877665544332211", bus.mem_in); end
  endtask

  task automatic test_gaps();
    logic [7:0] fr [9];
    fr = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clr_mon();
    for (int i = 0; i < 9; i++) begin
      send(8'(PID), fr[i], 1'b0);
      if (i < 8) send(8'd5, 8'($urandom), 1'b0);
    end
    send(8'd0, 8'd0, 1'b0);
    checks += 4;
    if (n_wen != 1)  begin errors++; $display("FAIL gaps_wen_count got=%0d exp=1", n_wen); end
    if (w_cyc != 17) begin errors++; $display("FAIL gaps_wen_cycle got=%0d exp=17", w_cyc); end
    if (w_addr !== 2'd2) begin errors++; $display("FAIL gaps_addr got=%0d exp=2", w_addr); end
    if (w_data !== 64'h8877665544332211) begin errors++; $display("FAIL gaps_data got=%h exp=8877665544332211", w_data); end
  endtask

  task automatic test_bad_addr();
    clr_mon();
    send(8'(PID), 8'h07, 1'b0);
    for (int i = 0; i < BYTES; i++) send(8'(PID), 8'($urandom), 1'b0);
    send(8'd0, 8'd0, 1'b0);
    checks += 8;
    if (n_wen != 0)  begin errors++; $display("FAIL bad_addr_wen got=%0d exp=0", n_wen); end
    if (n_done != 0) begin errors++; $display("FAIL bad_addr_done got=%0d exp=0", n_done); end
    if (n_err != 1)  begin errors++; $display("FAIL bad_addr_err_count got=%0d exp=1", n_err); end
    if (er_cyc != 9) begin errors++; $display("FAIL bad_addr_err_cycle got=%0d exp=9", er_cyc); end
    if (er_busy !== 1'b1) begin errors++; $display("FAIL bad_addr_busy_in_write got=%b exp=1", er_busy); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy_after got=%b exp=0", bus.busy); end
    if (bus.mem_address !== 2'd2) begin errors++; $display("FAIL bad_addr_hold_addr got=%0d exp=2", bus.mem_address); end
    if (bus.mem_in !== 64'h8877665544332211) begin errors++; $display("FAIL bad_addr_hold_data got=%h exp=8877665544332211", bus.mem_in); end
  endtask

  task automatic test_trace_abort();
    logic [7:0] d [BYTES];
    clr_mon();
    send(8'(PID), 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) send(8'(PID), 8'($urandom), 1'b0);
    send(8'(PID), 8'hAA, 1'b1);
    checks += 2;
    if (bus.error !== 1'b1) begin errors++; $display("FAIL abort_err got=%b exp=1", bus.error); end
    if (bus.busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    send(8'd0, 8'd0, 1'b0);
    checks += 1;
    if (bus.error !== 1'b0) begin errors++; $display("FAIL abort_err_pulse got=%b exp=0", bus.error); end
    for (int i = 0; i < BYTES; i++) d[i] = 8'($urandom);
    send(8'(PID), 8'h01, 1'b0);
    for (int i = 0; i < BYTES; i++) send(8'(PID), d[i], 1'b0);
    send(8'd0, 8'd0, 1'b0);
    checks += 4;
    if (n_wen != 1)  begin errors++; $display("FAIL abort_next_wen got=%0d exp=1", n_wen); end
    if (n_err != 1)  begin errors++; $display("FAIL abort_err_count got=%0d exp=1", n_err); end
    if (w_addr !== 2'd1) begin errors++; $display("FAIL abort_next_addr got=%0d exp=1", w_addr); end
    if (w_data !== pack(d)) begin errors++; $display("FAIL abort_next_data got=%h exp=%h", w_data, pack(d)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [BYTES];
    clr_mon();
    send(8'(PID), 8'h00, 1'b0);
    for (int i = 0; i < BYTES; i++) send(8'(PID), 8'($urandom), 1'b0);
    send(8'(PID), 8'h01, 1'b0);   // lands in the write cycle
    checks += 1;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_busy got=%b exp=0", bus.busy); end
    for (int i = 0; i < BYTES; i++) d[i] = 8'($urandom);
    send(8'(PID), 8'h03, 1'b0);
    for (int i = 0; i < BYTES; i++) send(8'(PID), d[i], 1'b0);
    send(8'd0, 8'd0, 1'b0);
    checks += 3;
    if (n_wen != 2)  begin errors++; $display("FAIL b2b_wen_count got=%0d exp=2", n_wen); end
    if (w_addr !== 2'd3) begin errors++; $display("FAIL b2b_addr got=%0d exp=3", w_addr); end
    if (w_data !== pack(d)) begin errors++; $display("FAIL b2b_data got=%h exp=%h", w_data, pack(d)); end
  endtask

  task automatic test_async_reset();
    clr_mon();
    send(8'(PID), 8'h02, 1'b0);
    for (int i = 0; i < 5; i++) send(8'(PID), 8'h60 + 8'(i), 1'b0);
    checks += 1;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", bus.busy); end
    #2 reset = 1'b1;
    #1;
    checks += 6;
    if (bus.busy !== 1'b0)             begin errors++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
    if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL areset_wen got=%b exp=0", bus.mem_write_enable); end
    if (bus.done !== 1'b0)             begin errors++; $display("FAIL areset_done got=%b exp=0", bus.done); end
    if (bus.error !== 1'b0)            begin errors++; $display("FAIL areset_error got=%b exp=0", bus.error); end
    if (bus.mem_address !== '0)        begin errors++; $display("FAIL areset_addr got=%h exp=0", bus.mem_address); end
    if (bus.mem_in !== '0)             begin errors++; $display("FAIL areset_mem_in got=%h exp=0", bus.mem_in); end
    #1 reset = 1'b0;
    model_clear();
    clr_mon();
    for (int i = 5; i < BYTES; i++) send(8'(PID), 8'h60 + 8'(i), 1'b0);
    repeat (3) send(8'd0, 8'd0, 1'b0);
    checks += 2;
    if (n_wen != 0) begin errors++; $display("FAIL areset_no_write got=%0d exp=0", n_wen); end
    if (n_err != 0) begin errors++; $display("FAIL areset_no_error got=%0d exp=0", n_err); end
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] id, dat;
    logic       trc;
    for (int n = 0; n < 1500; n++) begin
      id  = ($urandom_range(0, 3) == 0) ? 8'd5 : 8'(PID);
      trc = ($urandom_range(0, 39) == 0);
      if (m_q.size() == 0 && !m_wr) dat = 8'($urandom_range(0, 5));
      else                          dat = 8'($urandom_range(0, 255));
      send(id, dat, trc);
      checks += 6;
      if (bus.mem_write_enable !== e_wen) begin errors++; $display("FAIL rand_wen n=%0d got=%b exp=%b", n, bus.mem_write_enable, e_wen); end
      if (bus.done !== e_done)  begin errors++; $display("FAIL rand_done n=%0d got=%b exp=%b", n, bus.done, e_done); end
      if (bus.error !== e_err)  begin errors++; $display("FAIL rand_error n=%0d got=%b exp=%b", n, bus.error, e_err); end
      if (bus.busy !== e_busy)  begin errors++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, bus.busy, e_busy); end
      if (bus.mem_address !== e_addr) begin errors++; $display("FAIL rand_addr n=%0d got=%0d exp=%0d", n, bus.mem_address, e_addr); end
      if (bus.mem_in !== e_data) begin errors++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, bus.mem_in, e_data); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trace_idle();
    test_normal();
    test_gaps();
    test_bad_addr();
    test_trace_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
